// File: rtl/spi_ctrl_tx.sv
// spi_ctrl_tx: byte-wide SPI controller, MSB first, SPI modes 0-3, sclk half-period CLK_DIV clocks.
// Define SPI_CTRL_TX_MISO_EN to add full-duplex capture (miso in, rx_dat out).
module spi_ctrl_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] mode,
`ifdef SPI_CTRL_TX_MISO_EN
    input  logic       miso,
    output logic [7:0] rx_dat,
`endif
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic       done
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned TOG_W = 5;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_PRELAST = TOG_W'(15);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [TOG_W-1:0] tog_q, tog_d;
    logic [7:0]       sreg_q, sreg_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;

    logic             div_wrap;
    logic             accept;
    logic [TOG_W-1:0] tog_nxt;

    assign tx_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign div_wrap = (div_q == DIV_LAST);
    // Index e of the toggle that fires on the current wrap while in SHIFT.
    assign tog_nxt  = tog_q + TOG_W'(1);

    // Next-state and output decode; toggle 1 launches from SETUP, toggles 2..16 from SHIFT.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tog_d   = tog_q;
        sreg_d  = sreg_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = mode[1];
                if (accept) begin
                    sreg_d  = tx_dat;
                    cpol_d  = mode[1];
                    cpha_d  = mode[0];
                    cs_d    = 1'b0;
                    div_d   = '0;
                    tog_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_wrap) begin
                    div_d   = '0;
                    tog_d   = TOG_W'(1);
                    sclk_d  = ~cpol_q;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_wrap) begin
                    div_d  = '0;
                    tog_d  = tog_nxt;
                    sclk_d = ~sclk_q;
                    // Launch edges are the non-sample toggles; e=1 never lands here.
                    if (tog_nxt[0] == cpha_q) begin
                        sreg_d = {sreg_q[6:0], 1'b0};
                    end
                    if (tog_q == TOG_PRELAST) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (div_wrap) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                cs_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            tog_q   <= '0;
            sreg_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tog_q   <= tog_d;
            sreg_q  <= sreg_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign mosi = sreg_q[7];
    assign cs   = cs_q;
    assign done = done_q;

`ifdef SPI_CTRL_TX_MISO_EN
    logic [7:0] rx_sreg_q, rx_sreg_d;
    logic [7:0] rx_dat_q, rx_dat_d;
    logic       rx_sample;

    // Capture miso on every sample toggle; publish the byte alongside done.
    always_comb begin
        rx_sample = div_wrap &&
                    (((state_q == ST_SETUP) && !cpha_q) ||
                     ((state_q == ST_SHIFT) && (tog_nxt[0] != cpha_q)));
        rx_sreg_d = rx_sample ? {rx_sreg_q[6:0], miso} : rx_sreg_q;
        rx_dat_d  = done_d ? rx_sreg_q : rx_dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sreg_q <= '0;
            rx_dat_q  <= '0;
        end else begin
            rx_sreg_q <= rx_sreg_d;
            rx_dat_q  <= rx_dat_d;
        end
    end

    assign rx_dat = rx_dat_q;
`endif

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// tb_spi_ctrl_tx: scoreboard bench; a line-level monitor decodes each cs frame and checks it
// against bytes/modes queued by the driver at acceptance.
module tb_spi_ctrl_tx;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] mode = 2'b00;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       done;
`ifdef SPI_CTRL_TX_MISO_EN
    logic       miso;
    logic [7:0] rx_dat;
    assign miso = mosi;
`endif

    spi_ctrl_tx #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_dat   (tx_dat),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mode     (mode),
`ifdef SPI_CTRL_TX_MISO_EN
        .miso     (miso),
        .rx_dat   (rx_dat),
`endif
        .sclk     (sclk),
        .mosi     (mosi),
        .cs       (cs),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic [1:0] m;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   last_acc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: reconstructs each frame from the pins and scores it against the queue head.
    exp_t       cur;
    logic       in_frame = 1'b0;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       rise;
    int         tog = 0;
    int         nbits = 0;
    logic [7:0] rxb = 8'h00;
    int         rise_cyc = 0;
    int         last_gap = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (in_frame) void'(exp_q.pop_front());
            in_frame = 1'b0;
            tog = 0;
        end else begin
            if (prev_cs && !cs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(1), 32'(0));
                end else begin
                    cur = exp_q[0];
                    in_frame = 1'b1;
                    tog = 0;
                    nbits = 0;
                    rxb = 8'h00;
                    last_gap = cyc - rise_cyc;
                    check("cs_fall_time", 32'(cyc), 32'(cur.acc + 1));
                    check("sclk_idle_at_start", 32'(sclk), 32'(cur.m[1]));
                end
            end else if (in_frame && !cs && (sclk !== prev_sclk)) begin
                tog++;
                if (sclk == (cur.m[1] == cur.m[0])) begin
                    rxb = {rxb[6:0], mosi};
                    nbits++;
                end
            end
            rise = in_frame && !prev_cs && cs;
            if (rise || done) check("done_on_cs_rise", 32'(done), 32'(rise));
            if (rise) begin
                check("frame_byte", 32'(rxb), 32'(cur.b));
                check("frame_toggles", 32'(tog), 32'(16));
                check("frame_samples", 32'(nbits), 32'(8));
                check("done_time", 32'(cyc), 32'(cur.acc + 1 + 17 * D));
                check("sclk_idle_at_end", 32'(sclk), 32'(cur.m[1]));
`ifdef SPI_CTRL_TX_MISO_EN
                check("rx_dat_loopback", 32'(rx_dat), 32'(cur.b));
`endif
                void'(exp_q.pop_front());
                in_frame = 1'b0;
                rise_cyc = cyc;
            end
        end
        prev_cs = cs;
        prev_sclk = sclk;
    end

    // Present a byte and hold it until accepted; the expected frame is queued at acceptance.
    task automatic send(input logic [7:0] b, input logic [1:0] m, input bit hold);
        int w = 0;
        @(posedge clk);
        #1;
        tx_dat = b;
        mode = m;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) begin
            check("accept_timeout", 32'(0), 32'(1));
            tx_valid = 1'b0;
        end else begin
            exp_q.push_back('{b: b, m: m, acc: cyc});
            last_acc = cyc;
            @(posedge clk);
            #1;
            if (!hold) tx_valid = 1'b0;
        end
    endtask

    // Wait until the frame has been scored and the controller is ready again.
    task automatic finish_frame();
        int w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!(exp_q.size() == 0 && tx_ready) && w < 2000);
        check("ready_return_time", 32'(cyc), 32'(last_acc + 1 + 18 * D));
    endtask

    task automatic idle_sclk(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        @(negedge clk);
        check("idle_sclk_tracks_mode", 32'(sclk), 32'(m[1]));
    endtask

    initial begin
        int a1;
        int w;
        logic [7:0] rb;
        logic [1:0] rm;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 32'(cs), 32'(1));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_tx_ready", 32'(tx_ready), 32'(0));
`ifdef SPI_CTRL_TX_MISO_EN
        check("rst_rx_dat", 32'(rx_dat), 32'(0));
`endif
        #1 rst = 1'b0;

        idle_sclk(2'b10);
        idle_sclk(2'b00);

        send(8'hA5, 2'b00, 1'b0);
        finish_frame();

        for (int m = 1; m < 4; m++) begin
            idle_sclk(2'(m));
            send(8'h3C, 2'(m), 1'b0);
            finish_frame();
        end

        send(8'h01, 2'b00, 1'b1);
        a1 = last_acc;
        send(8'h80, 2'b00, 1'b0);
        check("b2b_second_accept", 32'(last_acc), 32'(a1 + 18 * D + 1));
        finish_frame();
        check("b2b_cs_high_gap", 32'(last_gap), 32'(D + 1));

        send(8'h96, 2'b01, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_dat = 8'hFF;
        mode = 2'b10;
        finish_frame();

        send(8'h5A, 2'b00, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (tog != 7 && w < 500);
        check("reach_toggle7", 32'(tog), 32'(7));
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(cs), 32'(1));
        check("abort_sclk", 32'(sclk), 32'(0));
        check("abort_mosi", 32'(mosi), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        #1 rst = 1'b0;
        check("abort_frame_dropped", 32'(exp_q.size()), 32'(0));
`ifdef SPI_CTRL_TX_MISO_EN
        check("rx_dat_zero_before_frame", 32'(rx_dat), 32'(0));
`endif
        send(8'hC3, 2'b11, 1'b0);
        finish_frame();

        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            rm = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send(rb, rm, 1'b0);
            finish_frame();
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
